// File: rtl/spike_enc_pkg.sv
// Shared types and packet field layout for the spike packet encoder and the router.
package spike_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EOT  = 2'd2
    } enc_state_e;

    // Plain-vector copies of the state codes for modules that keep state in logic.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_EOT  = EOT;

    localparam logic PKT_TYPE_SPIKE = 1'b0;
    localparam logic PKT_TYPE_EOT   = 1'b1;

    localparam int PKT_PAYLOAD_LSB = 0;

    function automatic int pkt_type_pos(input int pkt_w);
        return pkt_w - 1;
    endfunction

    function automatic int pkt_ts_msb(input int pkt_w);
        return pkt_w - 2;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder; found_o is low for an all-zero input.
module lsb_priority_enc #(
    parameter int N     = 256,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the lowest set bit is the last assignment to stick.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_packet_encoder.sv
// Serialises a per-timestep spike vector into one packet per fired neuron, lowest index first.
// Define SPIKE_ENC_EOT_EN to append an end-of-timestep packet carrying the spike count.
module spike_packet_encoder
    import spike_enc_pkg::*;
#(
    parameter int N_NEURONS = 256,
    parameter int IDX_W     = $clog2(N_NEURONS),
    parameter int TS_W      = 8,
    parameter int PKT_W     = 1 + TS_W + IDX_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_vec_i,
    input  logic                 spike_valid_i,
    output logic                 spike_ready_o,
    output logic [PKT_W-1:0]     pkt_o,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic                 busy_o,
    output logic [TS_W-1:0]      timestep_o
);

    localparam int TYPE_POS = pkt_type_pos(PKT_W);
    localparam int TS_MSB   = pkt_ts_msb(PKT_W);
    localparam logic [N_NEURONS-1:0] MASK_ONE = 1;
    localparam logic [TS_W-1:0]      TS_ONE   = 1;

    logic [1:0]           state_q, state_d;
    logic [N_NEURONS-1:0] mask_q, mask_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [IDX_W-1:0]     idx;
    logic                 found;
    logic [N_NEURONS-1:0] mask_rest;

`ifdef SPIKE_ENC_EOT_EN
    localparam logic [IDX_W:0] CNT_ONE = 1;
    logic [IDX_W:0] count_q, count_d;
`endif

    lsb_priority_enc #(
        .N     (N_NEURONS),
        .IDX_W (IDX_W)
    ) u_lsb_enc (
        .vec_i   (mask_q),
        .idx_o   (idx),
        .found_o (found)
    );

    // Clearing the lowest set bit is the same bit the encoder reports as idx.
    assign mask_rest = mask_q & (mask_q - MASK_ONE);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ts_d    = ts_q;
`ifdef SPIKE_ENC_EOT_EN
        count_d = count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (spike_valid_i) begin
                    mask_d = spike_vec_i;
`ifdef SPIKE_ENC_EOT_EN
                    count_d = '0;
                    state_d = (|spike_vec_i) ? ST_SCAN : ST_EOT;
`else
                    if (|spike_vec_i) state_d = ST_SCAN;
                    else              ts_d    = ts_q + TS_ONE;
`endif
                end
            end
            ST_SCAN: begin
                if (pkt_ready_i && found) begin
                    mask_d = mask_rest;
`ifdef SPIKE_ENC_EOT_EN
                    count_d = count_q + CNT_ONE;
                    if (mask_rest == '0) state_d = ST_EOT;
`else
                    if (mask_rest == '0) begin
                        state_d = ST_IDLE;
                        ts_d    = ts_q + TS_ONE;
                    end
`endif
                end
            end
`ifdef SPIKE_ENC_EOT_EN
            ST_EOT: begin
                if (pkt_ready_i) begin
                    state_d = ST_IDLE;
                    ts_d    = ts_q + TS_ONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_o       = '0;
        pkt_valid_o = 1'b0;
        case (state_q)
            ST_SCAN: begin
                pkt_valid_o                      = found;
                pkt_o[TYPE_POS]                  = PKT_TYPE_SPIKE;
                pkt_o[TS_MSB -: TS_W]            = ts_q;
                pkt_o[PKT_PAYLOAD_LSB +: IDX_W+1] = {1'b0, idx};
            end
`ifdef SPIKE_ENC_EOT_EN
            ST_EOT: begin
                pkt_valid_o                      = 1'b1;
                pkt_o[TYPE_POS]                  = PKT_TYPE_EOT;
                pkt_o[TS_MSB -: TS_W]            = ts_q;
                pkt_o[PKT_PAYLOAD_LSB +: IDX_W+1] = count_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ts_q    <= '0;
`ifdef SPIKE_ENC_EOT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ts_q    <= ts_d;
`ifdef SPIKE_ENC_EOT_EN
            count_q <= count_d;
`endif
        end
    end

    assign spike_ready_o = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign timestep_o    = ts_q;

endmodule
